// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: glitch-free 3-channel PWM for the RGB LED.
// Optional macro RGB_PWM_GAMMA_EN maps duty through g(d)=(d*d+d)>>8.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       period_start,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic          wrap;
  logic          wrap_q;

  logic          pend_valid;
  logic [7:0]    pend_r;
  logic [7:0]    pend_g;
  logic [7:0]    pend_b;
  logic [7:0]    act_r;
  logic [7:0]    act_g;
  logic [7:0]    act_b;
  logic [7:0]    duty_r;
  logic [7:0]    duty_g;
  logic [7:0]    duty_b;
  logic          accept;
  logic          commit;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (pwm_cnt == 8'hff);

  // reset holds the buffer closed; commit
  // looks only at the registered pend_valid
  assign in_ready = !pend_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign commit   = wrap && pend_valid;

  // prescaler: one pwm step every PRESCALE clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // pwm step counter, wraps 255 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // one-entry pending buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_r     <= '0;
      pend_g     <= '0;
      pend_b     <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_r     <= in_r;
      pend_g     <= in_g;
      pend_b     <= in_b;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // active duty only changes on a period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      act_r <= '0;
      act_g <= '0;
      act_b <= '0;
    end else if (commit) begin
      act_r <= pend_r;
      act_g <= pend_g;
      act_b <= pend_b;
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  function automatic logic [7:0] gamma_map(
    input logic [7:0] d
  );
    logic [15:0] dw;
    logic [15:0] sq;
    dw = {8'd0, d};
    sq = (dw * dw) + dw;
    return sq[15:8];
  endfunction

  assign duty_r = gamma_map(act_r);
  assign duty_g = gamma_map(act_g);
  assign duty_b = gamma_map(act_b);
`else
  assign duty_r = act_r;
  assign duty_g = act_g;
  assign duty_b = act_b;
`endif

  // registered compare keeps the pins glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      RGB_R <= 1'b0;
      RGB_G <= 1'b0;
      RGB_B <= 1'b0;
    end else begin
      RGB_R <= (pwm_cnt < duty_r);
      RGB_G <= (pwm_cnt < duty_g);
      RGB_B <= (pwm_cnt < duty_b);
    end
  end

  // period_start lines up with the pwm_cnt=0 sample
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wrap_q       <= wrap;
      period_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: self-checking bench for rgb_pwm_driver.
// Period-level reference model; PRESCALE 1 and 4 instances.
`timescale 1ns/1ps
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_g = '0;
  logic [7:0] in_b = '0;

  logic rdy1, ps1, r1, g1, b1;
  logic rdy4, ps4, r4, g4, b4;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .period_start(ps1),
    .RGB_R(r1), .RGB_G(g1), .RGB_B(b1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .period_start(ps4),
    .RGB_R(r4), .RGB_G(g4), .RGB_B(b4)
  );

  bit   sel4 = 1'b0;
  int   P = 1;
  int   W = 256;
  logic o_rdy, o_ps, o_r, o_g, o_b;

  assign o_rdy = sel4 ? rdy4 : rdy1;
  assign o_ps  = sel4 ? ps4  : ps1;
  assign o_r   = sel4 ? r4   : r1;
  assign o_g   = sel4 ? g4   : g1;
  assign o_b   = sel4 ? b4   : b1;

  typedef struct {
    int a; int w; int k;
    int r; int g; int b;
  } upd_t;
  typedef struct { int r; int g; int b; } trip_t;

  upd_t  mq[$];
  trip_t offers[$];
  int    t = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic set_mode(bit s);
    sel4 = s;
    P = s ? 4 : 1;
    W = 256 * P;
  endtask

  function automatic int gm(int d);
`ifdef RGB_PWM_GAMMA_EN
    return (d * d + d) / 256;
`else
    return d;
`endif
  endfunction

  // high cycles expected in output window k for channel ch
  function automatic int exp_high(int k, int ch);
    int d = 0;
    foreach (mq[i]) begin
      if (mq[i].k <= k) begin
        d = (ch == 0) ? mq[i].r :
            (ch == 1) ? mq[i].g : mq[i].b;
      end
    end
    return gm(d) * P;
  endfunction

  function automatic logic exp_ready(int tt);
    logic rv = 1'b1;
    foreach (mq[i]) begin
      if (mq[i].a < tt && tt <= mq[i].w) rv = 1'b0;
    end
    return rv;
  endfunction

  task automatic offer(int r, int g, int b);
    trip_t x;
    x.r = r; x.g = g; x.b = b;
    offers.push_back(x);
  endtask

  // present queued offers, log transfers, advance one cycle
  task automatic next();
    upd_t u;
    if (offers.size() > 0) begin
      in_valid = 1'b1;
      in_r = 8'(offers[0].r);
      in_g = 8'(offers[0].g);
      in_b = 8'(offers[0].b);
      if (o_rdy === 1'b1) begin
        u.a = t;
        u.k = (t + 1) / W + 1;
        u.w = u.k * W - 1;
        u.r = offers[0].r;
        u.g = offers[0].g;
        u.b = offers[0].b;
        mq.push_back(u);
        void'(offers.pop_front());
      end
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset(int n);
    offers.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    t = 0;
    #1;
  endtask

  // align to period_start and count one full period
  task automatic run_period(
    output int hr, output int hg, output int hb,
    output int hps, output logic [2:0] first,
    output int k, output bit to
  );
    int n = 0;
    hr = 0; hg = 0; hb = 0; hps = 0;
    first = '0; k = -1; to = 1'b0;
    while (o_ps !== 1'b1 && n < W + 4) begin
      next();
      n++;
    end
    if (o_ps !== 1'b1) begin
      to = 1'b1;
      return;
    end
    k = (t - 1) / W;
    first = {o_r, o_g, o_b};
    for (int i = 0; i < W; i++) begin
      hr  += (o_r  === 1'b1) ? 1 : 0;
      hg  += (o_g  === 1'b1) ? 1 : 0;
      hb  += (o_b  === 1'b1) ? 1 : 0;
      hps += (o_ps === 1'b1) ? 1 : 0;
      next();
    end
  endtask

  task automatic test_reset();
    int n = 0;
    set_mode(1'b0);
    offers.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({o_r, o_g, o_b, o_ps, o_rdy} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got %b want 00000",
          i, {o_r, o_g, o_b, o_ps, o_rdy});
      end
    end
    rst = 1'b0;
    mq.delete();
    t = 0;
    #1;
    n_chk++;
    if (o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", o_rdy);
    end
    while (o_ps !== 1'b1 && n < 600) begin
      next();
      n++;
    end
    // first pulse 257 edges after the last reset edge
    n_chk++;
    if (o_ps !== 1'b1 || t != W + 1) begin
      n_fail++;
      $display("FAIL reset_first_ps got t=%0d want %0d",
        t, W + 1);
    end
  endtask

  task automatic test_duty();
    int hr, hg, hb, hps, k, er, eg, eb;
    logic [2:0] first;
    bit to;
    set_mode(1'b0);
    do_reset(2);
    offer(64, 128, 255);
    for (int p = 0; p < 2; p++) begin
      run_period(hr, hg, hb, hps, first, k, to);
      er = exp_high(k, 0);
      eg = exp_high(k, 1);
      eb = exp_high(k, 2);
      n_chk++;
      if (to || k != p + 1 || hr != er || hg != eg ||
          hb != eb || hps != 1) begin
        n_fail++;
        $display("FAIL duty_p%0d got k=%0d r=%0d g=%0d b=%0d ps=%0d want k=%0d r=%0d g=%0d b=%0d ps=1",
          p, k, hr, hg, hb, hps, p + 1, er, eg, eb);
      end
      n_chk++;
      if (first !== {er != 0, eg != 0, eb != 0}) begin
        n_fail++;
        $display("FAIL duty_first_p%0d got %b want %b",
          p, first, {er != 0, eg != 0, eb != 0});
      end
    end
  endtask

  task automatic test_mid_period();
    int hr, hg, hb, hps, k, bad, er;
    logic [2:0] first;
    bit to, sent;
    set_mode(1'b0);
    do_reset(2);
    offer(50, 0, 0);
    run_period(hr, hg, hb, hps, first, k, to);
    er = exp_high(k, 0);
    n_chk++;
    if (to || k != 1 || hr != er) begin
      n_fail++;
      $display("FAIL mid_setup got k=%0d r=%0d want k=1 r=%0d",
        k, hr, er);
    end
    hr = 0;
    bad = 0;
    sent = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!sent && (t % W) == 100 * P) begin
        offer(200, 0, 0);
        sent = 1'b1;
      end
      hr += (o_r === 1'b1) ? 1 : 0;
      if (o_rdy !== exp_ready(t)) bad++;
      next();
    end
    er = exp_high(2, 0);
    n_chk++;
    if (hr != er) begin
      n_fail++;
      $display("FAIL mid_current got r=%0d want %0d", hr, er);
    end
    n_chk++;
    if (bad != 0 || mq.size() != 2) begin
      n_fail++;
      $display("FAIL mid_ready got bad=%0d acc=%0d want 0 2",
        bad, mq.size());
    end
    run_period(hr, hg, hb, hps, first, k, to);
    er = exp_high(k, 0);
    n_chk++;
    if (to || k != 3 || hr != er || hps != 1) begin
      n_fail++;
      $display("FAIL mid_next got k=%0d r=%0d ps=%0d want k=3 r=%0d ps=1",
        k, hr, hps, er);
    end
  endtask

  task automatic test_back_to_back();
    int hr, hg, hb, hps, k, bad, n, er, eg, eb;
    int ga, gb;
    logic [2:0] first;
    bit to;
    set_mode(1'b0);
    do_reset(2);
    offer($urandom_range(1, 255), $urandom_range(1, 255),
          $urandom_range(1, 255));
    offer($urandom_range(1, 255), $urandom_range(1, 255),
          $urandom_range(1, 255));
    bad = 0;
    n = 0;
    while (offers.size() > 0 && n < 3 * W) begin
      if (o_rdy !== exp_ready(t)) bad++;
      next();
      n++;
    end
    ga = -1;
    gb = -2;
    if (mq.size() == 2) begin
      ga = mq[0].w + 1;
      gb = mq[1].a;
    end
    n_chk++;
    if (offers.size() != 0 || mq.size() != 2 ||
        ga != gb || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_hs got acc=%0d at=%0d bad=%0d want acc=2 at=%0d bad=0",
        mq.size(), gb, bad, ga);
    end
    for (int p = 0; p < 2; p++) begin
      run_period(hr, hg, hb, hps, first, k, to);
      er = exp_high(k, 0);
      eg = exp_high(k, 1);
      eb = exp_high(k, 2);
      n_chk++;
      if (to || k != p + 1 || hr != er || hg != eg ||
          hb != eb || hps != 1) begin
        n_fail++;
        $display("FAIL b2b_p%0d got k=%0d r=%0d g=%0d b=%0d want k=%0d r=%0d g=%0d b=%0d",
          p, k, hr, hg, hb, p + 1, er, eg, eb);
      end
    end
  endtask

  task automatic test_prescale_reset();
    int hr, hg, hb, hps, k, n, er;
    logic [2:0] first;
    bit to;
    set_mode(1'b1);
    do_reset(2);
    offer(10, 0, 0);
    run_period(hr, hg, hb, hps, first, k, to);
    er = exp_high(k, 0);
    n_chk++;
    if (to || k != 1 || hr != er || hps != 1) begin
      n_fail++;
      $display("FAIL pre_duty got k=%0d r=%0d ps=%0d want k=1 r=%0d ps=1",
        k, hr, hps, er);
    end
    offer(99, 99, 99);
    n = 0;
    while ((t % W) != 5 * P && n < 2 * W) begin
      next();
      n++;
    end
    n_chk++;
    if (o_rdy !== 1'b0 || u_p4.pwm_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL pre_pending got rdy=%b cnt=%0d want 0 5",
        o_rdy, u_p4.pwm_cnt);
    end
    offers.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_r, o_g, o_b, o_ps, o_rdy} !== 5'b0) begin
      n_fail++;
      $display("FAIL pre_rst_out got %b want 00000",
        {o_r, o_g, o_b, o_ps, o_rdy});
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    t = 0;
    #1;
    n_chk++;
    if (u_p4.pwm_cnt !== 8'd0 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_restart got cnt=%0d rdy=%b want 0 1",
        u_p4.pwm_cnt, o_rdy);
    end
    run_period(hr, hg, hb, hps, first, k, to);
    n_chk++;
    if (to || k != 1 || hr != 0 || hg != 0 || hb != 0 ||
        hps != 1) begin
      n_fail++;
      $display("FAIL pre_dropped got k=%0d r=%0d g=%0d b=%0d want k=1 0 0 0",
        k, hr, hg, hb);
    end
  endtask

  task automatic test_gamma();
`ifdef RGB_PWM_GAMMA_EN
    int hr, hg, hb, hps, k;
    logic [2:0] first;
    bit to;
    set_mode(1'b0);
    do_reset(2);
    offer(128, 255, 1);
    run_period(hr, hg, hb, hps, first, k, to);
    n_chk++;
    if (to || hr != 64 || hg != 255 || hb != 0) begin
      n_fail++;
      $display("FAIL gamma got r=%0d g=%0d b=%0d want 64 255 0",
        hr, hg, hb);
    end
`endif
  endtask

  task automatic test_random();
    int hr, hg, hb, hps, k, er, eg, eb;
    logic [2:0] first;
    bit to;
    set_mode(1'b0);
    do_reset(2);
    offer(0, 255, $urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      offer($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255));
    end
    for (int p = 0; p < 6; p++) begin
      run_period(hr, hg, hb, hps, first, k, to);
      er = exp_high(k, 0);
      eg = exp_high(k, 1);
      eb = exp_high(k, 2);
      n_chk++;
      if (to || k != p + 1 || hr != er || hg != eg ||
          hb != eb || hps != 1) begin
        n_fail++;
        $display("FAIL rand_p%0d got k=%0d r=%0d g=%0d b=%0d ps=%0d want k=%0d r=%0d g=%0d b=%0d ps=1",
          p, k, hr, hg, hb, hps, p + 1, er, eg, eb);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_duty();
    test_mid_period();
    test_back_to_back();
    test_prescale_reset();
    test_gamma();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
